// File: rtl/bht_update_sched.sv
// Branch-history update scheduler: queues resolved branches and writes them to the BHT
// in lookup-idle cycles, and raises redirect/flush on a misprediction.
//
// state    | meaning
// ST_IDLE  | accepting resolved branches
// ST_FLUSH | flush asserted after a mispredict; new results are squashed
module bht_update_sched #(
   parameter int WIDTH_PC     = 32,
   parameter int DEPTH        = 4,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         res_valid,
   output logic                         res_ready,
   input  logic [WIDTH_PC-1:0]          res_pc,
   input  logic [WIDTH_PC-1:0]          res_target,
   input  logic                         res_taken,
   input  logic                         res_mispred,
   input  logic                         lookup_active,
   output logic                         lookup_block,
   output logic                         upd_valid,
   output logic [WIDTH_PC-1:0]          upd_pc,
   output logic [WIDTH_PC-1:0]          upd_target,
   output logic                         upd_taken,
   output logic                         redirect_valid,
   output logic [WIDTH_PC-1:0]          redirect_pc,
   output logic                         flush,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int FW = $clog2(FLUSH_CYCLES + 1);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_FLUSH = 1'b1;

   logic [WIDTH_PC-1:0] mem_pc  [DEPTH];
   logic [WIDTH_PC-1:0] mem_tgt [DEPTH];
   logic                mem_tk  [DEPTH];

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [0:0]    state;
   logic [FW-1:0] flush_cnt;
   logic          full;
   logic          push;
   logic          pop;

   assign full         = (count == CW'(DEPTH));
   assign res_ready    = !full && (state == ST_IDLE);
   assign push         = res_valid && res_ready;
   assign upd_valid    = (count != '0) && (!lookup_active || full);
   assign pop          = upd_valid;
   assign lookup_block = full;
   assign upd_pc       = mem_pc[rd_ptr];
   assign upd_target   = mem_tgt[rd_ptr];
   assign upd_taken    = mem_tk[rd_ptr];

   // Storage needs no reset: entries are only visible while count covers them.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_pc[wr_ptr]  <= res_pc;
         mem_tgt[wr_ptr] <= res_target;
         mem_tk[wr_ptr]  <= res_taken;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_IDLE;
         flush_cnt      <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         flush          <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               redirect_valid <= 1'b0;
               if (push && res_mispred) begin
                  state          <= ST_FLUSH;
                  redirect_valid <= 1'b1;
                  redirect_pc    <= res_taken ? res_target : res_pc + WIDTH_PC'(4);
                  flush          <= 1'b1;
                  flush_cnt      <= FW'(FLUSH_CYCLES - 1);
               end
            end
            ST_FLUSH: begin
               redirect_valid <= 1'b0;
               if (flush_cnt == '0) begin
                  state <= ST_IDLE;
                  flush <= 1'b0;
               end else begin
                  flush_cnt <= flush_cnt - FW'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
               flush <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bht_update_sched.sv
// Directed bench for bht_update_sched: queue-based reference model checked every cycle,
// plus literal expectations at the points of interest.
module tb_bht_update_sched;

   localparam int W  = 32;
   localparam int D  = 4;
   localparam int FC = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          res_valid, res_ready, res_taken, res_mispred;
   logic [W-1:0]  res_pc, res_target;
   logic          lookup_active, lookup_block;
   logic          upd_valid, upd_taken;
   logic [W-1:0]  upd_pc, upd_target;
   logic          redirect_valid, flush;
   logic [W-1:0]  redirect_pc;
   logic [2:0]    count;

   bht_update_sched #(.WIDTH_PC(W), .DEPTH(D), .FLUSH_CYCLES(FC)) dut (
      .clk(clk), .rst(rst),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_pc(res_pc), .res_target(res_target),
      .res_taken(res_taken), .res_mispred(res_mispred),
      .lookup_active(lookup_active), .lookup_block(lookup_block),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .flush(flush), .count(count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of outcomes and a count of remaining flush cycles.
   typedef struct packed { logic [W-1:0] pc; logic [W-1:0] tgt; logic tk; } ent_t;
   ent_t         q[$];
   int           m_flush_left = 0;
   logic         m_redir = 1'b0;
   logic [W-1:0] m_redir_pc = '0;
   bit           started = 0;

   function automatic logic m_ready();
      return (q.size() != D) && (m_flush_left == 0);
   endfunction

   function automatic logic m_upd();
      return (q.size() != 0) && (!lookup_active || q.size() == D);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         m_flush_left = 0;
         m_redir      = 1'b0;
         m_redir_pc   = '0;
      end else begin
         logic do_push, do_pop;
         do_push = res_valid && m_ready();
         do_pop  = m_upd();
         m_redir = 1'b0;
         if (m_flush_left > 0) m_flush_left--;
         if (do_pop) void'(q.pop_front());
         if (do_push) begin
            q.push_back('{pc: res_pc, tgt: res_target, tk: res_taken});
            if (res_mispred) begin
               m_flush_left = FC;
               m_redir      = 1'b1;
               m_redir_pc   = res_taken ? res_target : res_pc + 32'd4;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("m_count",     W'(count),          W'(q.size()));
         chk("m_ready",     W'(res_ready),      W'(m_ready()));
         chk("m_upd_valid", W'(upd_valid),      W'(m_upd()));
         chk("m_block",     W'(lookup_block),   W'(q.size() == D));
         chk("m_redir_v",   W'(redirect_valid), W'(m_redir));
         chk("m_redir_pc",  redirect_pc,        m_redir_pc);
         chk("m_flush",     W'(flush),          W'(m_flush_left > 0));
         if (q.size() != 0 && m_upd()) begin
            chk("m_upd_pc",  upd_pc,          q[0].pc);
            chk("m_upd_tgt", upd_target,      q[0].tgt);
            chk("m_upd_tk",  W'(upd_taken),   W'(q[0].tk));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [W-1:0] pc, input logic [W-1:0] tg,
                        input logic tk, input logic mp);
      res_valid = v; res_pc = pc; res_target = tg; res_taken = tk; res_mispred = mp;
   endtask

   initial begin
      rst = 1'b1; lookup_active = 1'b0;
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      repeat (3) step();
      started = 1;
      rst = 1'b0;
      step();
      chk("rst_count", W'(count), 0);
      chk("rst_upd_valid", W'(upd_valid), 0);
      chk("rst_flush", W'(flush), 0);
      chk("rst_ready", W'(res_ready), 1);

      // single correct push, drained immediately
      drive(1'b1, 32'h100, 32'h140, 1'b1, 1'b0);
      step();
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      chk("one_upd_valid", W'(upd_valid), 1);
      chk("one_upd_pc", upd_pc, 32'h100);
      chk("one_upd_tgt", upd_target, 32'h140);
      step();
      chk("one_count", W'(count), 0);
      chk("one_flush", W'(flush), 0);

      // fill while lookup is busy: full queue forces the drain
      lookup_active = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h1000 + 32'(i * 4), 32'h8000 + 32'(i), 1'b1, 1'b0);
         step();
      end
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      chk("full_count", W'(count), 4);
      chk("full_ready", W'(res_ready), 0);
      chk("full_block", W'(lookup_block), 1);
      chk("full_upd_valid", W'(upd_valid), 1);
      chk("full_upd_pc", upd_pc, 32'h1000);
      step();
      chk("full_after_pop", W'(count), 3);
      lookup_active = 1'b0;
      repeat (3) step();
      chk("full_drained", W'(count), 0);

      // simultaneous push/pop with wrap
      lookup_active = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i == 2) lookup_active = 1'b0;
         drive(1'b1, 32'h2000 + 32'(i * 4), 32'h3000 + 32'(i), i[0], 1'b0);
         step();
         if (i >= 2) chk("pp_count", W'(count), 2);
      end
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      chk("pp_head", upd_pc, 32'h2018);
      repeat (2) step();
      chk("pp_drained", W'(count), 0);

      // mispredict not-taken: redirect to pc+4, flush two cycles, entry still drained
      drive(1'b1, 32'h200, 32'h300, 1'b0, 1'b1);
      step();
      drive(1'b1, 32'h999, 32'h999, 1'b1, 1'b0);
      chk("mp_redir_v", W'(redirect_valid), 1);
      chk("mp_redir_pc", redirect_pc, 32'h204);
      chk("mp_flush1", W'(flush), 1);
      chk("mp_ready", W'(res_ready), 0);
      chk("mp_upd_pc", upd_pc, 32'h200);
      chk("mp_upd_tk", W'(upd_taken), 0);
      step();
      chk("mp_flush2", W'(flush), 1);
      chk("mp_redir_gone", W'(redirect_valid), 0);
      chk("mp_squashed", W'(count), 0);
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      step();
      chk("mp_flush_end", W'(flush), 0);
      chk("mp_ready_back", W'(res_ready), 1);

      // mispredict taken: redirect to target
      drive(1'b1, 32'h400, 32'h480, 1'b1, 1'b1);
      step();
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      chk("mpt_redir_pc", redirect_pc, 32'h480);
      repeat (3) step();

      // reset in the second flush cycle with three entries queued
      lookup_active = 1'b1;
      drive(1'b1, 32'h500, 32'h600, 1'b1, 1'b0); step();
      drive(1'b1, 32'h504, 32'h604, 1'b0, 1'b0); step();
      drive(1'b1, 32'h508, 32'h608, 1'b1, 1'b1); step();
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      step();
      chk("rmf_flush", W'(flush), 1);
      chk("rmf_count", W'(count), 3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rmf_flush_off", W'(flush), 0);
      chk("rmf_count0", W'(count), 0);
      chk("rmf_ready", W'(res_ready), 1);
      chk("rmf_redir_pc", redirect_pc, 0);
      lookup_active = 1'b0;
      repeat (3) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
